rom_string_streamer: RTL and testbench
======================================

// Module: rom_string_streamer
// PURPOSE
//  OBI manager that reads a NUL-terminated ASCII string from a word-addressed OBI
//  subordinate (the user-domain ROM) and streams it out one byte per valid/ready handshake.
//  It sits directly upstream of the ROM on its OBI port and feeds a character sink
//  (UART TX, debug FIFO). One read is outstanding at a time; the subordinate may grant
//  combinationally and respond any number of cycles after the grant.
// PARAMETERS
//  ObiCfg     obi_pkg::ObiDefaultConfig  OBI config (AddrWidth, DataWidth=32, IdWidth)
//  obi_req_t  logic                      OBI request struct type
//  obi_rsp_t  logic                      OBI response struct type
//  MaxChars   32                         hard cap on emitted chars per run (1..255)
// PORTS
//  clk_i         in   1          clock, all logic on rising edge
//  rst_i         in   1          asynchronous, active-high reset
//  start_i       in   1          start a run (sampled in IDLE only)
//  base_addr_i   in   AddrWidth  byte address of the string, word aligned; latched on start
//  busy_o        out  1          high in every state except IDLE
//  done_o        out  1          one-cycle pulse at end of run (normal, cap or error)
//  err_o         out  1          set when a read returns r.err; cleared on next accepted start
//  char_valid_o  out  1          char_o valid
//  char_ready_i  in   1          sink accepts char_o
//  char_o        out  8          current character
//  obi_req_o     out  obi_req_t  OBI manager request
//  obi_rsp_i     in   obi_rsp_t  OBI subordinate response
// BEHAVIOUR
//  Reset: state IDLE; busy_o, done_o, err_o, char_valid_o, char_o, obi_req_o.req = 0;
//   word index, byte lane, char count, latched word/base = 0. Reset mid-run aborts at once;
//   a response still in flight after reset is ignored (rvalid is only sampled in WAIT).
//  Request fields: a.we=0, a.be='1, a.wdata=0, a.aid=0, a.a_optional=0,
//   a.addr = base_q + 4*word_idx (AddrWidth wrap). r.rid is not checked.
//  FSM:
//   IDLE: start_i=1 -> latch base, clear idx/lane/count/err_o -> REQ.
//   REQ : req=1, addr stable until gnt; gnt=1 in same cycle -> WAIT.
//   WAIT: req=0; rvalid=1 & r.err=1 -> err_o<=1 -> DONE;
//         rvalid=1 & r.err=0 -> latch r.rdata, lane=0 -> EMIT.
//   EMIT: byte = word_q[8*lane+:8] (lane 0 first, little-endian).
//         byte==0 -> DONE, char_valid_o stays 0 (NUL never emitted).
//         else char_valid_o=1; on valid&ready: count++; count reaching MaxChars -> DONE;
//         else lane 3 -> idx++ -> REQ; else lane++ (stay EMIT).
//   DONE: done_o=1 for exactly this cycle -> IDLE.
//  Handshake: once char_valid_o rises, char_o held stable until char_ready_i; no
//   combinational path from char_ready_i to char_valid_o. Max 1 char/cycle.
//  start_i while busy_o=1 is ignored (no queueing). start_i in IDLE during the
//   done pulse cycle is not possible (DONE is a distinct state).
//  Latency: start -> req 1 cycle; gnt -> earliest rvalid 1 cycle (ROM 1-cycle);
//   rvalid -> first char_valid_o 1 cycle. Word index wraps at AddrWidth silently.
// TESTING
//  1 ROM "JD&JD's ASIC\0", base 0, ready=1 -> 12 chars 'J','D','&'...'C' in order,
//    4 reads at 0x0,0x4,0x8,0xC, done_o pulse once, err_o=0, NUL not emitted.
//  2 Same string, char_ready_i toggling 1/0 random -> identical byte sequence, char_o stable
//    while valid&!ready, no OBI req issued while chars of current word remain.
//  3 Subordinate sets r.err on 2nd read -> 4 chars emitted, err_o=1, done_o pulse; next
//    start clears err_o.
//  4 String with no NUL in 64 bytes, MaxChars=32 -> exactly 32 chars, 8 reads, done_o.
//  5 rst_i asserted while in WAIT with response due next cycle -> all outputs 0, state IDLE,
//    late rvalid ignored; new start fetches from base again.
//  6 start_i pulsed while busy -> ignored; ROM delaying gnt 3 cycles -> addr held stable, req=1.

Source files
------------

// File: rtl/rom_string_streamer.sv
// rom_string_streamer
// Reads a NUL-terminated ASCII string, one 32-bit word at a time, from a word-addressed
// OBI subordinate. It streams the characters out over a valid/ready byte interface,
// lane 0 first. There is never more than one OBI read outstanding.
// The obi_pkg below supplies the default configuration and the channel structs.

package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam int unsigned ObiAddrWidth = 32'd32;
  localparam int unsigned ObiDataWidth = 32'd32;
  localparam int unsigned ObiIdWidth   = 32'd1;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: ObiAddrWidth,
    DataWidth: ObiDataWidth,
    IdWidth:   ObiIdWidth
  };

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
    logic                      a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
    logic                    r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module rom_string_streamer #(
  parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned       MaxChars  = 32'd32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [ObiCfg.AddrWidth-1:0] base_addr_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        char_valid_o,
  input  logic                        char_ready_i,
  output logic [7:0]                  char_o,
  output obi_req_t                    obi_req_o,
  input  obi_rsp_t                    obi_rsp_i
);

  localparam int unsigned Aw = ObiCfg.AddrWidth;

  // The character cap fits in eight bits (1..255); the counter compares against it directly.
  localparam logic [7:0] MaxCharsC = MaxChars[7:0];

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Picks one byte of a fetched word; lane 0 is the least significant byte.
  function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] lane);
    select_byte = word[{lane, 3'b000} +: 8];
  endfunction

  // Current state and datapath registers.
  state_e         state_r;
  logic [Aw-1:0]  base_r;
  logic [Aw-1:0]  idx_r;
  logic [1:0]     lane_r;
  logic [7:0]     cnt_r;
  logic [31:0]    word_r;
  logic           err_r;

  // Registered outputs, computed from the next-state view so they line up with the state.
  logic           busy_r;
  logic           done_r;
  logic           valid_r;
  logic [7:0]     char_r;
  logic           req_r;
  logic [Aw-1:0]  addr_r;

  // Next-state values.
  state_e         state_s;
  logic [Aw-1:0]  base_s;
  logic [Aw-1:0]  idx_s;
  logic [1:0]     lane_s;
  logic [7:0]     cnt_s;
  logic [31:0]    word_s;
  logic           err_s;
  logic [7:0]     cur_byte_s;
  logic [7:0]     next_byte_s;
  logic [Aw-1:0]  next_addr_s;
  logic           handshake_s;

  // rid, r_optional and any unused rdata bits are deliberately ignored.
  logic           unused_s;
  assign unused_s = ^obi_rsp_i;

  // Byte currently presented, and whether the sink takes it this cycle. The handshake
  // is gated by the registered valid, so ready never feeds back into valid.
  always_comb begin
    cur_byte_s  = select_byte(word_r, lane_r);
    handshake_s = valid_r & char_ready_i;
  end

  // Next-state and datapath update for the fetch/emit sequence.
  always_comb begin
    state_s = state_r;
    base_s  = base_r;
    idx_s   = idx_r;
    lane_s  = lane_r;
    cnt_s   = cnt_r;
    word_s  = word_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          base_s  = base_addr_i;
          idx_s   = '0;
          lane_s  = 2'd0;
          cnt_s   = 8'd0;
          err_s   = 1'b0;
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (obi_rsp_i.gnt) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            err_s   = 1'b1;
            state_s = ST_DONE;
          end else begin
            word_s  = obi_rsp_i.r.rdata[31:0];
            lane_s  = 2'd0;
            state_s = ST_EMIT;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (cur_byte_s == 8'd0) begin
          // The terminator ends the run and is never presented to the sink.
          state_s = ST_DONE;
        end else if (handshake_s) begin
          cnt_s = cnt_r + 8'd1;
          if (cnt_s == MaxCharsC) begin
            state_s = ST_DONE;
          end else if (lane_r == 2'd3) begin
            // The word is used up; only now is the next one requested.
            idx_s   = idx_r + {{(Aw-1){1'b0}}, 1'b1};
            lane_s  = 2'd0;
            state_s = ST_REQ;
          end else begin
            lane_s  = lane_r + 2'd1;
            state_s = ST_EMIT;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Values the registered outputs take on the next edge.
  always_comb begin
    next_byte_s = select_byte(word_s, lane_s);
    next_addr_s = base_s + (idx_s << 2);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      base_r  <= '0;
      idx_r   <= '0;
      lane_r  <= 2'd0;
      cnt_r   <= 8'd0;
      word_r  <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      base_r  <= base_s;
      idx_r   <= idx_s;
      lane_r  <= lane_s;
      cnt_r   <= cnt_s;
      word_r  <= word_s;
      err_r   <= err_s;
    end
  end

  // Output registers. Valid only rises for a non-NUL byte, and both the byte and the
  // valid flag hold while EMIT waits for the sink.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      char_r  <= 8'd0;
      req_r   <= 1'b0;
      addr_r  <= '0;
    end else begin
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      valid_r <= (state_s == ST_EMIT) && (next_byte_s != 8'd0);
      char_r  <= (state_s == ST_EMIT) ? next_byte_s : 8'd0;
      req_r   <= (state_s == ST_REQ);
      addr_r  <= next_addr_s;
    end
  end

  // Drive the port signals from the output registers. This is a read-only request,
  // so the fixed request fields are tied off here.
  always_comb begin
    obi_req_o              = '0;
    obi_req_o.req          = req_r;
    obi_req_o.a.addr       = addr_r;
    obi_req_o.a.we         = 1'b0;
    obi_req_o.a.be         = '1;
    obi_req_o.a.wdata      = '0;
    obi_req_o.a.aid        = '0;
    obi_req_o.a.a_optional = '0;
    busy_o                 = busy_r;
    done_o                 = done_r;
    err_o                  = err_r;
    char_valid_o           = valid_r;
    char_o                 = char_r;
  end

endmodule

// File: tb/tb_rom_string_streamer.sv
// Testbench for rom_string_streamer: a behavioural ROM subordinate, queue scoreboards
// for the expected characters and read addresses, and one task per scenario.
`timescale 1ns/1ps

module tb_rom_string_streamer;
  import obi_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_data;
  obi_req_t    obi_req;
  obi_rsp_t    obi_rsp;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int emitted = 0;
  bit rand_ready = 1'b0;

  logic [7:0]  exp_chars [$];
  logic [31:0] exp_addrs [$];

  // ROM model state
  logic [7:0]  mem [0:255];
  int          gnt_delay = 0;
  int          resp_lat = 1;
  int          err_at = -1;
  int          wait_cnt = 0;
  int          resp_cnt = 0;
  int          rd_total = 0;
  logic [31:0] rdata_q = 32'd0;
  logic        err_q = 1'b0;

  rom_string_streamer #(
    .MaxChars(32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .char_valid_o (char_valid),
    .char_ready_i (char_ready),
    .char_o       (char_data),
    .obi_req_o    (obi_req),
    .obi_rsp_i    (obi_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subordinate response: grant after gnt_delay waiting cycles, response resp_lat cycles later.
  always_comb begin
    obi_rsp         = '0;
    obi_rsp.gnt     = obi_req.req && (wait_cnt >= gnt_delay);
    obi_rsp.rvalid  = (resp_cnt == 1);
    obi_rsp.r.rdata = rdata_q;
    obi_rsp.r.err   = err_q;
  end

  // ROM sequencing. This model is not reset by rst, so a response can still arrive late.
  always @(posedge clk) begin
    if (obi_req.req && obi_rsp.gnt) begin
      wait_cnt <= 0;
      resp_cnt <= resp_lat;
      rd_total <= rd_total + 1;
      err_q    <= ((rd_total + 1) == err_at);
      rdata_q  <= {mem[{obi_req.a.addr[7:2], 2'b11}], mem[{obi_req.a.addr[7:2], 2'b10}],
                   mem[{obi_req.a.addr[7:2], 2'b01}], mem[{obi_req.a.addr[7:2], 2'b00}]};
    end else begin
      wait_cnt <= obi_req.req ? wait_cnt + 1 : 0;
      if (resp_cnt != 0) resp_cnt <= resp_cnt - 1;
    end
  end

  // Watchdog: stops the run if the scenario sequence stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic run_monitor();
    bit         hold_p = 1'b0;
    logic [7:0] hold_c = 8'd0;
    bit         done_p = 1'b0;
    logic [7:0] e;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_p = 1'b0;
        done_p = 1'b0;
      end else begin
        if (hold_p) begin
          checks++;
          if (char_valid !== 1'b1 || char_data !== hold_c) begin
            errors++;
            $display("FAIL hold_stable: valid=%0b char=%02h, required valid=1 char=%02h",
                     char_valid, char_data, hold_c);
          end
        end
        if (char_valid && char_ready) begin
          emitted++;
          checks++;
          if (exp_chars.size() == 0) begin
            errors++;
            $display("FAIL unexpected_char: got %02h, required no character", char_data);
          end else begin
            e = exp_chars.pop_front();
            if (char_data !== e) begin
              errors++;
              $display("FAIL char_value: got %02h, required %02h", char_data, e);
            end
          end
        end
        if (obi_req.req) begin
          checks++;
          if (char_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_while_chars: req=1 with char_valid=%0b, required char_valid=0", char_valid);
          end
        end
        if (obi_req.req && obi_rsp.gnt) begin
          checks++;
          if (exp_addrs.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: addr %08h, required no read", obi_req.a.addr);
          end else begin
            ea = exp_addrs.pop_front();
            if (obi_req.a.addr !== ea || obi_req.a.we !== 1'b0 || obi_req.a.be !== 4'hF) begin
              errors++;
              $display("FAIL read_req: addr=%08h we=%0b be=%h, required addr=%08h we=0 be=f",
                       obi_req.a.addr, obi_req.a.we, obi_req.a.be, ea);
            end
          end
        end
        if (done) begin
          done_cnt++;
          checks++;
          if (done_p) begin
            errors++;
            $display("FAIL done_width: done_o high 2 cycles, required 1");
          end
        end
        hold_p = char_valid && !char_ready;
        hold_c = char_data;
        done_p = done;
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1;
      char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
  endtask

  // Writes the string into ROM and queues the first n_exp characters as expected output.
  task automatic load_str(input int base, input string s, input int n_exp);
    for (int i = 0; i < s.len(); i++) begin
      mem[(base + i) % 256] = s[i];
      if (i < n_exp) exp_chars.push_back(s[i]);
    end
  endtask

  task automatic expect_reads(input int base, input int n);
    for (int i = 0; i < n; i++) exp_addrs.push_back(32'(base + 4 * i));
  endtask

  task automatic start_run(input logic [31:0] b);
    @(posedge clk);
    #1;
    base_addr = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no done_o within %0d cycles, required one pulse", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  // Compares the run bookkeeping against expected deltas; queues must be drained.
  task automatic check_run(input string name, input int d0, input int e0, input int r0,
                           input int n_chars, input int n_reads, input logic exp_err);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt - d0);
    end
    checks++;
    if (emitted - e0 !== n_chars) begin
      errors++;
      $display("FAIL %s_char_count: got %0d, required %0d", name, emitted - e0, n_chars);
    end
    checks++;
    if (rd_total - r0 !== n_reads) begin
      errors++;
      $display("FAIL %s_read_count: got %0d, required %0d", name, rd_total - r0, n_reads);
    end
    checks++;
    if (exp_chars.size() !== 0 || exp_addrs.size() !== 0) begin
      errors++;
      $display("FAIL %s_leftover: chars=%0d reads=%0d pending, required 0 0",
               name, exp_chars.size(), exp_addrs.size());
    end
    checks++;
    if (err !== exp_err || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: err=%0b busy=%0b, required err=%0b busy=0", name, err, busy, exp_err);
    end
    exp_chars.delete();
    exp_addrs.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || char_valid !== 1'b0 ||
        char_data !== 8'd0 || obi_req.req !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%0b done=%0b err=%0b valid=%0b char=%02h req=%0b, required all 0",
               name, busy, done, err, char_valid, char_data, obi_req.req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_basic_string();
    int d0 = done_cnt, e0 = emitted, r0 = rd_total;
    clear_mem();
    load_str(0, "JD&JD's ASIC", 12);
    expect_reads(0, 4);
    start_run(32'h0);
    wait_done(400, "basic");
    check_run("basic", d0, e0, r0, 12, 4, 1'b0);
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt, e0 = emitted, r0 = rd_total;
    clear_mem();
    load_str(0, "JD&JD's ASIC", 12);
    expect_reads(0, 4);
    rand_ready = 1'b1;
    start_run(32'h0);
    wait_done(800, "backpressure");
    rand_ready = 1'b0;
    check_run("backpressure", d0, e0, r0, 12, 4, 1'b0);
  endtask

  task automatic test_read_error();
    int d0 = done_cnt, e0 = emitted, r0 = rd_total;
    clear_mem();
    load_str(32'h40, "ABCDEFGHIJ", 4);
    expect_reads(32'h40, 2);
    err_at = rd_total + 2;
    start_run(32'h40);
    wait_done(400, "read_error");
    err_at = -1;
    check_run("read_error", d0, e0, r0, 4, 2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%0b, required 1 while idle", err);
    end
    d0 = done_cnt; e0 = emitted; r0 = rd_total;
    load_str(32'h60, "ok", 2);
    expect_reads(32'h60, 1);
    start_run(32'h60);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_start: err=%0b, required 0", err);
    end
    wait_done(400, "after_error");
    check_run("after_error", d0, e0, r0, 2, 1, 1'b0);
  endtask

  task automatic test_max_chars();
    int d0 = done_cnt, e0 = emitted, r0 = rd_total;
    string s = "";
    clear_mem();
    for (int i = 0; i < 64; i++) s = {s, string'(8'(8'd97 + 8'(i % 26)))};
    load_str(32'h80, s, 32);
    expect_reads(32'h80, 8);
    start_run(32'h80);
    wait_done(600, "max_chars");
    check_run("max_chars", d0, e0, r0, 32, 8, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int d0, e0, r0;
    clear_mem();
    load_str(32'h10, "RESET", 0);
    expect_reads(32'h10, 1);
    resp_lat = 2;
    start_run(32'h10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("reset_in_wait");
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check_idle_outputs("late_rvalid_ignored");
    end
    checks++;
    if (exp_addrs.size() !== 0) begin
      errors++;
      $display("FAIL aborted_read: %0d reads pending, required 0", exp_addrs.size());
    end
    resp_lat = 1;
    d0 = done_cnt; e0 = emitted; r0 = rd_total;
    load_str(32'h10, "RESET", 5);
    expect_reads(32'h10, 2);
    start_run(32'h10);
    wait_done(400, "restart");
    check_run("restart", d0, e0, r0, 5, 2, 1'b0);
  endtask

  task automatic test_busy_start_and_gnt_delay();
    int d0 = done_cnt, e0 = emitted, r0 = rd_total;
    clear_mem();
    load_str(32'h20, "HOLD ME", 7);
    load_str(32'h60, "XY", 0);
    expect_reads(32'h20, 2);
    gnt_delay = 3;
    start_run(32'h20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (obi_req.req !== 1'b1 || obi_req.a.addr !== 32'h20 || obi_rsp.gnt !== 1'b0) begin
        errors++;
        $display("FAIL gnt_wait_hold: req=%0b addr=%08h gnt=%0b, required req=1 addr=00000020 gnt=0",
                 obi_req.req, obi_req.a.addr, obi_rsp.gnt);
      end
    end
    @(posedge clk);
    #1;
    base_addr = 32'h60;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(600, "busy_start");
    gnt_delay = 0;
    repeat (5) @(posedge clk);
    #1;
    check_run("busy_start", d0, e0, r0, 7, 2, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = 32'h0;
    char_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    fork
      run_monitor();
      drive_ready();
    join_none
    test_reset();
    test_basic_string();
    test_backpressure();
    test_read_error();
    test_max_chars();
    test_reset_mid_run();
    test_busy_start_and_gnt_delay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
